out_port_reader: RTL and testbench

OUT_PORT_READER -- requirements
Module: out_port_reader

---
 rtl/out_port_reader.sv | 120 ++++++++++++
 tb/tb_out_port_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_reader.sv
// -----------------------------------------------------------------------------
// out_port_reader
//
// Buffers words written by the CPU to its output port and hands them to an
// external device over a valid/ready interface. The buffer is a small FIFO
// whose head is presented combinationally. A write that arrives while the
// FIFO is full, with no pop on the same edge, is dropped and raises a sticky
// overflow flag.
//
// Parameters
//   DW     : width of the CPU output-port word
//   DEPTH  : number of FIFO entries (power of two, 2..16)
//
// Ports
//   clock      in   single clock, rising edge
//   Reset      in   asynchronous, active-low reset
//   OutPortin  in   CPU write strobe; BusMuxOut is pushed on this edge
//   BusMuxOut  in   CPU bus data [DW]
//   dev_data   out  head FIFO entry [DW]
//   dev_valid  out  dev_data holds a valid word
//   dev_ready  in   device accepts the head word
//   full       out  FIFO holds DEPTH entries
//   empty      out  FIFO holds no entries
//   count      out  current occupancy [log2(DEPTH)+1]
//   overflow   out  sticky: a write was dropped
//   clr_ovf    in   synchronous clear of overflow (a drop on the same edge wins)
//   words_out  out  words accepted by the device, modulo 2^16
// -----------------------------------------------------------------------------
module out_port_reader #(
  parameter int  DW    = 32,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          OutPortin,
  input  logic [DW-1:0] BusMuxOut,
  output logic [DW-1:0] dev_data,
  output logic          dev_valid,
  input  logic          dev_ready,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          clr_ovf,
  output logic [15:0]   words_out
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [15:0]   r_words_out;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A pop frees the head slot on the same edge, so a full FIFO can still
  // accept a write when the device takes a word in that cycle.
  assign w_pop  = !w_empty && dev_ready;
  assign w_push = OutPortin && (!w_full || w_pop);
  assign w_drop = OutPortin && w_full && !w_pop;

  // NOTE: the storage array has no reset; every entry is written before it can
  // become the head, and keeping reset off it lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= BusMuxOut;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_words_out <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_words_out <= r_words_out + 16'd1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Set has priority over clear.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign dev_data  = r_mem[r_rd_ptr];
  assign dev_valid = !w_empty;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign words_out = r_words_out;

endmodule

// File: tb/tb_out_port_reader.sv
// -----------------------------------------------------------------------------
// tb_out_port_reader
//
// Self-checking bench for out_port_reader (DW=32, DEPTH=4). A queue-based
// reference model tracks the FIFO contents, the overflow flag and the pop
// counter from the behavioural rules; every clock cycle the DUT outputs are
// compared with it, and directed scenarios add explicit value checks.
// -----------------------------------------------------------------------------
module tb_out_port_reader;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clock;
  logic          Reset;
  logic          OutPortin;
  logic [DW-1:0] BusMuxOut;
  logic [DW-1:0] dev_data;
  logic          dev_valid;
  logic          dev_ready;
  logic          full;
  logic          empty;
  logic [2:0]    count;
  logic          overflow;
  logic          clr_ovf;
  logic [15:0]   words_out;

  out_port_reader #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .Reset     (Reset),
    .OutPortin (OutPortin),
    .BusMuxOut (BusMuxOut),
    .dev_data  (dev_data),
    .dev_valid (dev_valid),
    .dev_ready (dev_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .words_out (words_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [DW-1:0] m_q [$];
  logic          m_ovf;
  logic [15:0]   m_wo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check("count",     32'(count),     32'(m_q.size()));
    check("empty",     32'(empty),     32'(m_q.size() == 0));
    check("full",      32'(full),      32'(m_q.size() == DEPTH));
    check("dev_valid", 32'(dev_valid), 32'(m_q.size() != 0));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("words_out", 32'(words_out), 32'(m_wo));
    if (m_q.size() != 0) check("dev_data", dev_data, m_q[0]);
  endtask

  // One clock cycle with the currently driven inputs; the model advances
  // by the same rules and all outputs are compared 1 time unit after the edge.
  task automatic step();
    bit            pop, push, drop;
    int            sz;
    logic [DW-1:0] wdata;
    sz    = m_q.size();
    wdata = BusMuxOut;
    pop   = (sz != 0) && dev_ready;
    push  = OutPortin && ((sz < DEPTH) || pop);
    drop  = OutPortin && (sz == DEPTH) && !pop;
    @(posedge clock);
    #1;
    if (pop) begin
      void'(m_q.pop_front());
      m_wo = m_wo + 16'd1;
    end
    if (push) m_q.push_back(wdata);
    if (clr_ovf) m_ovf = 1'b0;
    if (drop)    m_ovf = 1'b1;
    check_model();
  endtask

  task automatic drive(input logic wr, input logic [DW-1:0] d, input logic rdy);
    OutPortin = wr;
    BusMuxOut = d;
    dev_ready = rdy;
    clr_ovf   = 1'b0;
  endtask

  // Asserts reset between edges, checks the asynchronous clear before the
  // next edge, then releases it away from the edge.
  task automatic do_reset(input string tag);
    #2;
    Reset = 1'b0;
    #1;
    check({tag, "_count"},     32'(count),     32'd0);
    check({tag, "_empty"},     32'(empty),     32'd1);
    check({tag, "_full"},      32'(full),      32'd0);
    check({tag, "_valid"},     32'(dev_valid), 32'd0);
    check({tag, "_overflow"},  32'(overflow),  32'd0);
    check({tag, "_words_out"}, 32'(words_out), 32'd0);
    m_q.delete();
    m_ovf = 1'b0;
    m_wo  = '0;
    drive(1'b0, '0, 1'b0);
    @(posedge clock);
    #2;
    Reset = 1'b1;
    @(posedge clock);
    #1;
    check_model();
  endtask

  initial begin
    logic [DW-1:0] exp_seq [$];
    int            guard;

    Reset = 1'b1;
    drive(1'b0, '0, 1'b0);
    m_ovf = 1'b0;
    m_wo  = '0;
    #3;
    do_reset("rst0");

    // Three pushes held, then drained in order.
    foreach (exp_seq[i]) ;
    drive(1'b1, 32'h11, 1'b0); step();
    drive(1'b1, 32'h22, 1'b0); step();
    drive(1'b1, 32'h33, 1'b0); step();
    drive(1'b0, '0, 1'b0);
    check("fill3_count", 32'(count), 32'd3);
    check("fill3_head",  dev_data,   32'h11);
    exp_seq = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1);
      check("drain3_word", dev_data, exp_seq[i]);
      step();
    end
    drive(1'b0, '0, 1'b0);
    check("drain3_empty", 32'(empty),     32'd1);
    check("drain3_wo",    32'(words_out), 32'd3);

    // Fill to full, then a dropped write.
    do_reset("rst1");
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 1'b0);
      step();
    end
    drive(1'b1, 32'hFF, 1'b0); step();
    drive(1'b0, '0, 1'b0);
    check("ovf_full",  32'(full),     32'd1);
    check("ovf_count", 32'(count),    32'd4);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_head",  dev_data,      32'hA0);

    // Write while full with a pop on the same edge is accepted.
    drive(1'b1, 32'hB0, 1'b1); step();
    drive(1'b0, '0, 1'b0);
    check("fullpp_count", 32'(count),    32'd4);
    check("fullpp_ovf",   32'(overflow), 32'd1);
    exp_seq = '{32'hA1, 32'hA2, 32'hA3, 32'hB0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1);
      check("fullpp_order", dev_data, exp_seq[i]);
      step();
    end
    drive(1'b0, '0, 1'b0);
    check("fullpp_empty", 32'(empty), 32'd1);

    // Clear overflow, then clear and drop on the same edge (set wins).
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hC0 + 32'(i), 1'b0);
      step();
    end
    drive(1'b1, 32'hEE, 1'b0);
    clr_ovf = 1'b1;
    step();
    drive(1'b0, '0, 1'b0);
    check("set_wins", 32'(overflow), 32'd1);

    // Mid-operation reset with count=3 and overflow=1.
    drive(1'b0, '0, 1'b1); step();
    drive(1'b0, '0, 1'b0);
    check("pre_rst_count", 32'(count),    32'd3);
    check("pre_rst_ovf",   32'(overflow), 32'd1);
    do_reset("rst_mid");

    // Ten continuous push/pop pairs across the pointer wrap.
    for (int i = 0; i < 11; i++) begin
      drive(i < 10, 32'h100 + 32'(i), 1'b1);
      if (i > 0) check("stream_order", dev_data, 32'h100 + 32'(i - 1));
      step();
      check("stream_count_le1", 32'(count <= 3'd1), 32'd1);
    end
    drive(1'b0, '0, 1'b0);
    check("stream_wo",    32'(words_out), 32'd10);
    check("stream_empty", 32'(empty),     32'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      OutPortin = ($urandom_range(0, 99) < 60);
      BusMuxOut = $urandom();
      dev_ready = ($urandom_range(0, 99) < 45);
      clr_ovf   = ($urandom_range(0, 99) < 8);
      step();
    end
    drive(1'b0, '0, 1'b0);

    // Drive words_out to 0xFFFF by streaming, then one more pop wraps it.
    do_reset("rst_wrap");
    guard = 0;
    while (m_wo != 16'hFFFF && guard < 70000) begin
      drive(1'b1, $urandom(), 1'b1);
      step();
      guard++;
    end
    drive(1'b0, '0, 1'b0);
    check("wo_at_ffff", 32'(words_out), 32'h0000FFFF);
    drive(1'b0, '0, 1'b1); step();
    drive(1'b0, '0, 1'b0);
    check("wo_wrap", 32'(words_out), 32'h0);
    check("wo_wrap_empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
